// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, lane-select constants and alignment helpers for
//               the MEM-stage access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

    // Big-endian lanes: bit 3 is byte offset 0.
    localparam logic [3:0] c_SEL_BYTE0 = 4'b1000;
    localparam logic [3:0] c_SEL_HALF0 = 4'b1100;
    localparam logic [3:0] c_SEL_HALF2 = 4'b0011;
    localparam logic [3:0] c_SEL_WORD  = 4'b1111;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_SW);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
            MEM_LW, MEM_SW:          mis = (off != 2'b00);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_fmt
// Description : Combinational byte-lane steering for stores and lane
//               extraction with sign/zero extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [3:0]  i_st_op,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_sel,
    output logic [31:0] o_st_wdata,
    input  logic [3:0]  i_ld_op,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_sel      = 4'b0000;
        o_st_wdata = 32'h0;
        case (i_st_op)
            MEM_LB, MEM_LBU, MEM_SB: o_sel = c_SEL_BYTE0 >> i_st_off;
            MEM_LH, MEM_LHU, MEM_SH: o_sel = i_st_off[1] ? c_SEL_HALF2 : c_SEL_HALF0;
            MEM_LW, MEM_SW:          o_sel = c_SEL_WORD;
            default:                 o_sel = 4'b0000;
        endcase
        case (i_st_op)
            MEM_SB:  o_st_wdata = {4{i_st_data[7:0]}};
            MEM_SH:  o_st_wdata = {2{i_st_data[15:0]}};
            MEM_SW:  o_st_wdata = i_st_data;
            default: o_st_wdata = 32'h0;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_ld_off)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_ld_off[1] ? i_rdata[15:0] : i_rdata[31:16];
        case (i_ld_op)
            MEM_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_ld_data = {24'h0, w_byte};
            MEM_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_ld_data = {16'h0, w_half};
            MEM_LW:  o_ld_data = i_rdata;
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage load/store sequencer onto a req/ack data bus with
//               pipeline stall, write-back, misalignment and timeout handling.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int N_REG       = 32,
    parameter int N_REG_ADDR  = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wen,
    input  logic [N_REG_ADDR-1:0] i_waddr,
    input  logic [N_REG-1:0]      i_wdata,
    input  logic [3:0]            i_mem_op,
    input  logic [31:0]           i_mem_addr,
    input  logic [N_REG-1:0]      i_store_data,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [31:0]           o_bus_addr,
    output logic [3:0]            o_bus_sel,
    output logic [N_REG-1:0]      o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic [N_REG-1:0]      i_bus_rdata,
    output logic                  o_stall_req,
    output logic                  o_wen,
    output logic [N_REG_ADDR-1:0] o_waddr,
    output logic [N_REG-1:0]      o_wdata,
    output logic                  o_addr_err,
    output logic                  o_bus_err
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [3:0]            r_op;
    logic [1:0]            r_off;
    logic [N_REG_ADDR-1:0] r_waddr;
    logic [N_REG-1:0]      r_load_data;
    logic                  r_timeout;
    logic                  r_bus_we;
    logic [31:0]           r_bus_addr;
    logic [3:0]            r_bus_sel;
    logic [N_REG-1:0]      r_bus_wdata;

    logic                  w_is_mem;
    logic                  w_misaligned;
    logic [3:0]            w_sel;
    logic [31:0]           w_st_wdata;
    logic [31:0]           w_ld_data;

    assign w_is_mem     = is_mem_op(i_mem_op);
    assign w_misaligned = is_misaligned(i_mem_op, i_mem_addr[1:0]);

    // Store side follows the incoming instruction; load side the latched one.
    mem_lane_fmt u_lane_fmt (
        .i_st_op    (i_mem_op),
        .i_st_off   (i_mem_addr[1:0]),
        .i_st_data  (i_store_data),
        .o_sel      (w_sel),
        .o_st_wdata (w_st_wdata),
        .i_ld_op    (r_op),
        .i_ld_off   (r_off),
        .i_rdata    (i_bus_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= MEM_NONE;
            r_off       <= 2'b00;
            r_waddr     <= '0;
            r_load_data <= '0;
            r_timeout   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem && !w_misaligned) begin
                        r_bus_we    <= !is_load(i_mem_op);
                        r_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                        r_bus_sel   <= w_sel;
                        r_bus_wdata <= w_st_wdata;
                        r_op        <= i_mem_op;
                        r_off       <= i_mem_addr[1:0];
                        r_waddr     <= i_waddr;
                        r_cnt       <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_bus_ack) begin
                        r_load_data <= w_ld_data;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_bus_req    = 1'b0;
        o_stall_req  = 1'b0;
        o_wen        = 1'b0;
        o_waddr      = '0;
        o_wdata      = '0;
        o_addr_err   = 1'b0;
        o_bus_err    = 1'b0;
        // Reset forces the combinational outputs low as well as the state.
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_is_mem) begin
                        o_wen   = i_wen;
                        o_waddr = i_waddr;
                        o_wdata = i_wdata;
                    end else if (w_misaligned) begin
                        o_addr_err = 1'b1;
                    end else begin
                        o_stall_req  = 1'b1;
                        w_state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    o_bus_req   = 1'b1;
                    o_stall_req = 1'b1;
                    if (i_bus_ack || (r_cnt == c_CNT_LAST)) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                    if (r_timeout) begin
                        o_bus_err = 1'b1;
                    end else if (is_load(r_op)) begin
                        o_wen   = 1'b1;
                        o_waddr = r_waddr;
                        o_wdata = r_load_data;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_sel   = r_bus_sel;
    assign o_bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a behavioural
//               cycle model and directed load/store/error vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_wen;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic [3:0]  i_mem_op;
    logic [31:0] i_mem_addr;
    logic [31:0] i_store_data;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_stall_req;
    logic        o_wen;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_addr_err;
    logic        o_bus_err;

    always #5 i_clk = ~i_clk;

    mem_access_ctrl #(
        .N_REG       (32),
        .N_REG_ADDR  (5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wen        (i_wen),
        .i_waddr      (i_waddr),
        .i_wdata      (i_wdata),
        .i_mem_op     (i_mem_op),
        .i_mem_addr   (i_mem_addr),
        .i_store_data (i_store_data),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_sel    (o_bus_sel),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata),
        .o_stall_req  (o_stall_req),
        .o_wen        (o_wen),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_addr_err   (o_addr_err),
        .o_bus_err    (o_bus_err)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic        e_bus_req, e_bus_we, e_stall, e_wen, e_addr_err, e_bus_err;
    logic [31:0] e_bus_addr, e_bus_wdata, e_wdata;
    logic [3:0]  e_bus_sel;
    logic [4:0]  e_waddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes, from the opcode alone.
    function automatic int msize(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_sel(input logic [3:0] op, input logic [1:0] off);
        int sz;
        sz = msize(op);
        if (sz == 4) return 4'hF;
        if (sz == 2) return (off == 2'd0) ? 4'hC : 4'h3;
        return 4'b1000 >> off;
    endfunction

    function automatic logic [31:0] model_store(input logic [3:0] op, input logic [31:0] sd);
        longint unsigned v;
        case (msize(op))
            1:       v = (longint'(sd) & 64'hFF) * 64'h01010101;
            2:       v = (longint'(sd) & 64'hFFFF) * 64'h00010001;
            default: v = longint'(sd);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
        longint v, span;
        int sz;
        sz   = msize(op);
        span = longint'(1) << (8 * sz);
        v    = (longint'(rd) >> (8 * (4 - int'(off) - sz))) % span;
        if ((op == MEM_LB || op == MEM_LH) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic clear_exp();
        e_bus_req = 0; e_bus_we = 0; e_bus_addr = 0; e_bus_sel = 0; e_bus_wdata = 0;
        e_stall = 0; e_wen = 0; e_waddr = 0; e_wdata = 0; e_addr_err = 0; e_bus_err = 0;
    endtask

    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("bus_req",  32'(o_bus_req),   32'(e_bus_req));
            chk("stall",    32'(o_stall_req), 32'(e_stall));
            chk("wen",      32'(o_wen),       32'(e_wen));
            chk("waddr",    32'(o_waddr),     32'(e_waddr));
            chk("wdata",    o_wdata,          e_wdata);
            chk("addr_err", 32'(o_addr_err),  32'(e_addr_err));
            chk("bus_err",  32'(o_bus_err),   32'(e_bus_err));
            if (e_bus_req || i_rst) begin
                chk("bus_we",   32'(o_bus_we),  32'(e_bus_we));
                chk("bus_addr", o_bus_addr,     e_bus_addr);
                chk("bus_sel",  32'(o_bus_sel), 32'(e_bus_sel));
                if (e_bus_we || i_rst) chk("bus_wdata", o_bus_wdata, e_bus_wdata);
            end
        end
    end

    task automatic step();
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
    endtask

    task automatic none_cycle(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ack);
        i_mem_op = MEM_NONE; i_wen = wen; i_waddr = wa; i_wdata = wd;
        i_mem_addr = 32'h0000_0103; i_bus_ack = ack; i_bus_rdata = 32'h1234_5678;
        clear_exp();
        e_wen = wen; e_waddr = wa; e_wdata = wd;
        step();
    endtask

    // One full instruction: IDLE, BUSY cycles (ack on ack_at, 0 = never), DONE.
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] wa, input int ack_at, input logic [31:0] rd,
                          input logic [3:0] lit_sel, input logic [31:0] lit_val, input bit stray);
        int sz, nbusy;
        bit ld, mis, acked;
        sz    = msize(op);
        ld    = (op >= MEM_LB) && (op <= MEM_LW);
        mis   = (sz != 0) && ((addr % sz) != 0);
        acked = (ack_at >= 1) && (ack_at <= TMO);
        nbusy = acked ? ack_at : TMO;
        i_mem_op = op; i_mem_addr = addr; i_store_data = sd; i_waddr = wa;
        i_wen = ld; i_wdata = 32'hA100_0000 | addr; i_bus_ack = 0; i_bus_rdata = 32'h0;
        clear_exp();
        if (mis) e_addr_err = 1; else e_stall = 1;
        @(negedge i_clk);
        if (mis) chk("lit_addr_err", 32'(o_addr_err), 32'd1);
        @(posedge i_clk);
        #1;
        if (!mis) begin
            for (int k = 1; k <= nbusy; k++) begin
                clear_exp();
                e_bus_req = 1; e_stall = 1; e_bus_we = !ld;
                e_bus_addr  = addr & 32'hFFFF_FFFC;
                e_bus_sel   = model_sel(op, addr[1:0]);
                e_bus_wdata = model_store(op, sd);
                i_bus_ack   = acked && (k == nbusy);
                i_bus_rdata = i_bus_ack ? rd : ~rd;
                @(negedge i_clk);
                if (k == 1) begin
                    chk("lit_sel", 32'(o_bus_sel), 32'(lit_sel));
                    if (!ld) chk("lit_bus_wdata", o_bus_wdata, lit_val);
                end
                @(posedge i_clk);
                #1;
            end
            clear_exp();
            i_bus_ack = stray; i_bus_rdata = 32'hFFFF_FFFF;
            if (!acked) e_bus_err = 1;
            else if (ld) begin
                e_wen = 1; e_waddr = wa; e_wdata = model_load(op, addr[1:0], rd);
            end
            @(negedge i_clk);
            if (ld && acked) chk("lit_load", o_wdata, lit_val);
            if (!acked) chk("lit_bus_err", 32'(o_bus_err), 32'd1);
            @(posedge i_clk);
            #1;
        end
        i_bus_ack = 0;
    endtask

    initial begin
        i_rst = 1; i_wen = 0; i_waddr = 0; i_wdata = 0; i_mem_op = MEM_NONE;
        i_mem_addr = 0; i_store_data = 0; i_bus_ack = 0; i_bus_rdata = 0;
        clear_exp();
        cmp_en = 1;
        @(negedge i_clk);
        chk("lit_reset_wen", 32'(o_wen), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 0;
        none_cycle(1'b1, 5'd9, 32'h0BAD_F00D, 1'b1);

        access(MEM_LW,  32'h100, 32'h0,         5'd4,  2, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0);
        none_cycle(1'b0, 5'd1, 32'h1, 1'b0);
        access(MEM_LB,  32'h203, 32'h0,         5'd5,  1, 32'h112233F0, 4'b0001, 32'hFFFFFFF0, 1'b0);
        access(MEM_LBU, 32'h203, 32'h0,         5'd6,  3, 32'h112233F0, 4'b0001, 32'h000000F0, 1'b1);
        none_cycle(1'b1, 5'd2, 32'h2222, 1'b1);
        access(MEM_LH,  32'h202, 32'h0,         5'd7,  1, 32'h00008001, 4'b0011, 32'hFFFF8001, 1'b0);
        access(MEM_LHU, 32'h200, 32'h0,         5'd8,  2, 32'h80017FFF, 4'b1100, 32'h00008001, 1'b0);
        access(MEM_SH,  32'h012, 32'h0000ABCD,  5'd10, 1, 32'h0,        4'b0011, 32'hABCDABCD, 1'b1);
        access(MEM_SB,  32'h041, 32'h000000A5,  5'd11, 2, 32'h0,        4'b0100, 32'hA5A5A5A5, 1'b0);
        access(MEM_SW,  32'h044, 32'h12345678,  5'd12, 4, 32'h0,        4'b1111, 32'h12345678, 1'b0);
        access(MEM_LW,  32'h102, 32'h0,         5'd13, 1, 32'h0,        4'b0000, 32'h0,        1'b0);
        none_cycle(1'b1, 5'd14, 32'hCAFE, 1'b0);
        access(MEM_LH,  32'h201, 32'h0,         5'd15, 1, 32'h0,        4'b0000, 32'h0,        1'b0);
        access(MEM_LW,  32'h500, 32'h0,         5'd16, 0, 32'h0,        4'b1111, 32'h0,        1'b0);
        none_cycle(1'b0, 5'd0, 32'h0, 1'b1);
        access(MEM_LB,  32'h080, 32'h0,         5'd17, 4, 32'h7F000000, 4'b1000, 32'h0000007F, 1'b0);

        // Reset in the second BUSY cycle of a load.
        i_mem_op = MEM_LW; i_mem_addr = 32'h300; i_wen = 1; i_waddr = 5'd20;
        i_wdata = 32'h0; i_bus_ack = 0;
        clear_exp(); e_stall = 1;
        step();
        clear_exp(); e_bus_req = 1; e_stall = 1; e_bus_addr = 32'h300; e_bus_sel = 4'hF;
        step();
        i_rst = 1;
        clear_exp();
        #1;
        chk("lit_rst_req",   32'(o_bus_req),   32'd0);
        chk("lit_rst_stall", 32'(o_stall_req), 32'd0);
        chk("lit_rst_wen",   32'(o_wen),       32'd0);
        step();
        i_rst = 0;
        i_mem_op = MEM_NONE; i_wen = 1; i_waddr = 5'd3; i_wdata = 32'd7;
        clear_exp(); e_wen = 1; e_waddr = 5'd3; e_wdata = 32'd7;
        @(negedge i_clk);
        chk("lit_pass_wdata", o_wdata, 32'd7);
        chk("lit_pass_waddr", 32'(o_waddr), 32'd3);
        @(posedge i_clk);
        #1;
        none_cycle(1'b0, 5'd0, 32'h0, 1'b0);

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences load/store instructions in the MEM stage onto a single-master data bus with a req/ack handshake.
- Stalls the pipeline while an access is outstanding, then presents the register write-back (wen/waddr/wdata) to the MEM/WB register.
- Non-memory instructions pass through with zero added latency.
- Byte-lane steering, sign/zero extension, misalignment detection and bus timeout are handled here.

Parameters:
- N_REG, 32, register/data width (fixed 32; byte-lane logic assumes 4 lanes).
- N_REG_ADDR, 5, register file address width.
- TIMEOUT_CYC, 255, max BUSY cycles without i_bus_ack before abort (>=1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_wen  in  1  write-enable from EX/MEM.
- i_waddr  in  N_REG_ADDR  destination register.
- i_wdata  in  N_REG  ALU result, used for non-memory ops.
- i_mem_op  in  4  mem_op_e: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- i_mem_addr  in  32  effective byte address.
- i_store_data  in  N_REG  store source (rt).
- o_bus_req  out  1  bus request; held until ack.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  word address, {i_mem_addr[31:2],2'b00}.
- o_bus_sel  out  4  byte enables, bit3 = byte offset 0 (big-endian).
- o_bus_wdata  out  N_REG  lane-replicated store data.
- i_bus_ack  in  1  single-cycle completion.
- i_bus_rdata  in  N_REG  read data, valid with ack.
- o_stall_req  out  1  to pipeline controller; holds the MEM-stage instruction.
- o_wen  out  1  write-back enable.
- o_waddr  out  N_REG_ADDR  write-back address.
- o_wdata  out  N_REG  write-back data.
- o_addr_err  out  1  misaligned access, 1-cycle flag.
- o_bus_err  out  1  timeout, 1-cycle pulse.

Behaviour:
- Reset (async, immediate): state=IDLE, timeout counter=0, bus regs cleared. o_bus_req=0, o_bus_we=0, o_bus_addr=0, o_bus_sel=0, o_bus_wdata=0. o_stall_req=0, o_wen=0, o_waddr=0, o_wdata=0, o_addr_err=0, o_bus_err=0. Reset mid-BUSY drops o_bus_req the same instant; the ack is not awaited.
- FSM states: IDLE, BUSY, DONE.
- IDLE, i_mem_op=NONE: o_wen/o_waddr/o_wdata = inputs (combinational). o_stall_req=0.
- IDLE, aligned memory op:
  - o_stall_req=1 combinationally; o_wen=0.
  - Register bus fields and op/waddr. Next state BUSY.
- IDLE, misaligned op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - No bus access, no stall, o_addr_err=1, o_wen=0. Stay IDLE.
- BUSY:
  - o_bus_req=1; we/addr/sel/wdata stable. o_stall_req=1, o_wen=0. Counter increments each cycle.
  - i_bus_ack: capture formatted load data (loads), go DONE.
  - Counter reaches TIMEOUT_CYC without ack: drop req, o_bus_err=1 for 1 cycle, go DONE with write-back suppressed.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - o_stall_req=0, o_bus_req=0.
  - Load without error: o_wen=1, o_waddr=latched, o_wdata=formatted data. Store or error: o_wen=0.
  - Next state IDLE unconditionally; the pipeline advances at the end of DONE.
- Latency: an access takes 1 (IDLE) + N (BUSY, ack on the Nth cycle) + 1 (DONE) cycles. Minimum 3 with same-cycle ack in the first BUSY cycle.
- Lane rules (big-endian; off = addr[1:0]):
  - SB: sel=1000>>off, wdata={4{b}}.
  - SH: sel=1100 (off 0) or 0011 (off 2), wdata={2{h}}.
  - SW: sel=1111.
  - Loads: sel per op as above, we=0.
  - LB/LH sign-extend; LBU/LHU zero-extend. Byte off0 = rdata[31:24]; half off0 = rdata[31:16].
- Stray i_bus_ack in IDLE/DONE is ignored.

Decomposition:
- Package mem_pkg holds:
  - mem_op_e (4-bit enum).
  - ctrl_state_e (IDLE/BUSY/DONE).
  - Lane-select constants.
  - Alignment-check function.
- Sub-module mem_lane_fmt (combinational):
  - Store side: op+offset+store_data -> sel/wdata.
  - Load side: op+offset+rdata -> extended load data.

Test Plan:
- LW @0x100, ack on 2nd BUSY cycle, rdata=0xDEADBEEF -> stall high 3 cycles; DONE: wen=1, wdata=0xDEADBEEF; bus_addr=0x100, sel=1111.
- LB @0x203, rdata=0x112233F0 -> sel=0001, wdata=0xFFFFFFF0. LBU same -> 0x000000F0. LH @0x202, rdata=0x00008001 -> 0xFFFF8001.
- SH @0x10 offset 2, store_data=0x0000ABCD -> bus_we=1, sel=0011, wdata=0xABCDABCD; DONE wen=0.
- LW @0x102 -> o_addr_err=1 for 1 cycle, bus_req never asserted, stall=0, wen=0.
- TIMEOUT_CYC=4, no ack -> req high 4 cycles, o_bus_err pulse, wen=0, back to IDLE.
- Assert i_rst in the 2nd BUSY cycle -> req/stall/wen drop immediately. After release, NONE op with i_wen=1, waddr=3, wdata=7 passes through the same cycle.
